rv32_alu: RTL and testbench
===========================

Name: rv32_alu

Overview:
- Integer execute unit of the RISC-V core: RV32I arithmetic, logic, shift and compare operations, plus RV32M multiply, divide and remainder.
- Operands come from the operand-select stage. The single registered result feeds writeback/forwarding.
- Fully pipelined, one result per cycle, fixed latency of 1 clock.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the opcode semantics below assume 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  32  operand A (rs1 or PC).
- b  input  32  operand B (rs2 or immediate); shifts use b[4:0].
- alu_op  input  5  operation select; encodings come from the shared parameters header.
- result  output  32  registered result.

Behaviour:
- Latency:
  - On each rising clk, result <= f(alu_op, a, b) using the values present before the edge.
  - A change of a, b or alu_op is visible on result after exactly one edge.
  - No handshake, no stall; a new operation is accepted every cycle.
- Reset: if rst = 1 at a rising edge, result <= 0. Reset has priority over any operation in flight. result stays 0 while rst is held.
- Opcode map, alu_op value : function:
  - 0 ALU_ADD: a+b, mod 2^32.
  - 1 ALU_SUB: a-b, mod 2^32.
  - 2 ALU_XOR.
  - 3 ALU_OR.
  - 4 ALU_AND.
  - 5 ALU_SSL: a << b[4:0].
  - 6 ALU_SRL: logical right shift by b[4:0].
  - 7 ALU_SRA: arithmetic right shift by b[4:0], sign-filled.
  - 8 ALU_SLT: 1 if signed a < signed b, else 0.
  - 9 ALU_SLTU: 1 if unsigned a < unsigned b, else 0.
  - 10 ALU_MUL: low 32 bits of a*b.
  - 11 ALU_MULH: high 32 bits of the signed×signed 64-bit product.
  - 12 ALU_MULHSU: high 32 bits of signed a × unsigned b.
  - 13 ALU_MULHU: high 32 bits of unsigned×unsigned.
  - 14 ALU_DIV: signed quotient, truncated toward zero.
  - 15 ALU_DIVU: unsigned quotient.
  - 16 ALU_REM: signed remainder; sign follows the dividend.
  - 17 ALU_REMU: unsigned remainder.
  - 18-31: result <= 0.
- Shift and compare rules:
  - b[31:5] is ignored for all shifts.
  - SLT/SLTU results are zero-extended to 32 bits.
- Division boundary cases (RISC-V M):
  - b = 0: DIV and DIVU give 0xFFFFFFFF; REM and REMU give a.
  - a = 0x80000000 with b = 0xFFFFFFFF, signed: DIV gives 0x80000000 and REM gives 0; no trap.
- Division implementation: single-cycle combinational multiply/divide feeding the output register is acceptable. No exceptions or flags are produced.

Optional Feature:
- Macro: ALU_MEXT_EN.
- Defined: opcodes 10-17 (MUL..REMU) behave as specified above.
- Undefined:
  - Multiplier and divider logic is not instantiated.
  - Opcodes 10-17 produce result <= 0, like other unused codes.
  - Base-ISA opcodes 0-9 are unchanged.

Test Plan:
- Reset: rst = 1 with a = 5, b = 3, ADD, for 2 cycles -> result = 0. Release rst -> result = 8 one edge later.
- Arithmetic and logic:
  - ADD 0xFFFFFFFF + 1 -> 0.
  - SUB 0 - 1 -> 0xFFFFFFFF.
  - XOR 0xF0F0F0F0 ^ 0xFF00FF00 -> 0x0FF00FF0.
  - 1000 random a, b per op for ops 0-4, each checked against a software model.
- Shifts and compares:
  - SRA 0x80000000 by b = 0x21 -> 0xC0000000 (only b[4:0] = 1 used).
  - SRL same inputs -> 0x40000000.
  - SLT 0xFFFFFFFF vs 1 -> 1.
  - SLTU same inputs -> 0.
- Multiply:
  - MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0.
  - MULHU same inputs -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
  - MUL 0x10000 × 0x10000 -> 0.
- Divide edge cases:
  - DIV -7 / 2 -> -3; REM -7 % 2 -> -1.
  - DIV x / 0 -> 0xFFFFFFFF; REMU 9 % 0 -> 9.
  - DIV 0x80000000 / -1 -> 0x80000000; REM same inputs -> 0.
- Build without ALU_MEXT_EN: MUL 3 × 4 -> 0, ADD still correct. Opcode 25 -> 0 in both builds.

Source files
------------

// File: rtl/rv32_alu.sv
// RV32I/RV32M integer execute unit with a single registered result (latency 1).
// Define ALU_MEXT_EN to build the multiply/divide path; otherwise opcodes 10-17 return 0.
module rv32_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      alu_op,
    output logic [XLEN-1:0] result
);

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_XOR    = 5'd2;
    localparam logic [4:0] ALU_OR     = 5'd3;
    localparam logic [4:0] ALU_AND    = 5'd4;
    localparam logic [4:0] ALU_SSL    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_SLT    = 5'd8;
    localparam logic [4:0] ALU_SLTU   = 5'd9;
`ifdef ALU_MEXT_EN
    localparam logic [4:0] ALU_MUL    = 5'd10;
    localparam logic [4:0] ALU_MULH   = 5'd11;
    localparam logic [4:0] ALU_MULHSU = 5'd12;
    localparam logic [4:0] ALU_MULHU  = 5'd13;
    localparam logic [4:0] ALU_DIV    = 5'd14;
    localparam logic [4:0] ALU_DIVU   = 5'd15;
    localparam logic [4:0] ALU_REM    = 5'd16;
    localparam logic [4:0] ALU_REMU   = 5'd17;
`endif

    logic [XLEN-1:0] result_d;
    logic [XLEN-1:0] result_q;
    logic [4:0]      shamt;

    assign shamt = b[4:0];

`ifdef ALU_MEXT_EN
    // One shared 64-bit multiplier: operands are sign- or zero-extended per opcode,
    // and the low 64 bits of the extended product are exact for all four variants.
    logic              mul_a_signed;
    logic              mul_b_signed;
    logic [63:0]       mul_a_ext;
    logic [63:0]       mul_b_ext;
    logic [63:0]       mul_prod;

    assign mul_a_signed = (alu_op == ALU_MULH) || (alu_op == ALU_MULHSU);
    assign mul_b_signed = (alu_op == ALU_MULH);
    assign mul_a_ext    = {{32{mul_a_signed & a[31]}}, a};
    assign mul_b_ext    = {{32{mul_b_signed & b[31]}}, b};
    assign mul_prod     = mul_a_ext * mul_b_ext;

    // One shared unsigned divider; signed ops divide magnitudes and fix signs after.
    logic              div_signed;
    logic              div_by_zero;
    logic [XLEN-1:0]   a_abs;
    logic [XLEN-1:0]   b_abs;
    logic [XLEN-1:0]   dvd;
    logic [XLEN-1:0]   dvs;
    logic [XLEN-1:0]   quo_mag;
    logic [XLEN-1:0]   rem_mag;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;

    assign div_signed  = (alu_op == ALU_DIV) || (alu_op == ALU_REM);
    assign div_by_zero = (b == '0);
    assign a_abs       = a[31] ? (~a + 1'b1) : a;
    assign b_abs       = b[31] ? (~b + 1'b1) : b;
    assign dvd         = div_signed ? a_abs : a;
    assign dvs         = div_by_zero ? {{(XLEN-1){1'b0}}, 1'b1} : (div_signed ? b_abs : b);
    assign quo_mag     = dvd / dvs;
    assign rem_mag     = dvd % dvs;
    // 0x80000000 / -1 falls out naturally: magnitude 0x80000000, positive sign.
    assign quo_s       = (a[31] ^ b[31]) ? (~quo_mag + 1'b1) : quo_mag;
    assign rem_s       = a[31] ? (~rem_mag + 1'b1) : rem_mag;
`endif

    always_comb begin
        result_d = '0;
        case (alu_op)
            ALU_ADD:    result_d = a + b;
            ALU_SUB:    result_d = a - b;
            ALU_XOR:    result_d = a ^ b;
            ALU_OR:     result_d = a | b;
            ALU_AND:    result_d = a & b;
            ALU_SSL:    result_d = a << shamt;
            ALU_SRL:    result_d = a >> shamt;
            ALU_SRA:    result_d = $unsigned($signed(a) >>> shamt);
            ALU_SLT:    result_d = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:   result_d = {{(XLEN-1){1'b0}}, (a < b)};
`ifdef ALU_MEXT_EN
            ALU_MUL:    result_d = mul_prod[31:0];
            ALU_MULH:   result_d = mul_prod[63:32];
            ALU_MULHSU: result_d = mul_prod[63:32];
            ALU_MULHU:  result_d = mul_prod[63:32];
            ALU_DIV:    result_d = div_by_zero ? '1 : quo_s;
            ALU_DIVU:   result_d = div_by_zero ? '1 : quo_mag;
            ALU_REM:    result_d = div_by_zero ? a : rem_s;
            ALU_REMU:   result_d = div_by_zero ? a : rem_mag;
`endif
            default:    result_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_rv32_alu.sv
// Directed and randomized checks of rv32_alu; M-extension expectations follow ALU_MEXT_EN.
module tb_rv32_alu;

`ifdef ALU_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  alu_op;
    logic [31:0] result;

    int total;
    int bad;

    rv32_alu #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .alu_op (alu_op),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] op,
                         input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] exp);
        alu_op = op;
        a      = va;
        b      = vb;
        @(posedge clk);
        #1;
        total++;
        assert (result === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, result, exp);
        end
    endtask

    function automatic logic [31:0] base_model(input logic [4:0] op,
                                               input logic [31:0] x,
                                               input logic [31:0] y);
        case (op)
            5'd0:    return x + y;
            5'd1:    return x - y;
            5'd2:    return x ^ y;
            5'd3:    return x | y;
            5'd4:    return x & y;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mx(input logic [31:0] v);
        return MEXT ? v : 32'h0;
    endfunction

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        a      = 32'd5;
        b      = 32'd3;
        alu_op = 5'd0;

        // reset held for two edges with an ADD presented
        @(posedge clk);
        #1;
        total++;
        assert (result === 32'h0) else begin
            bad++;
            $error("FAIL rst_cyc1: observed=%h expected=%h", result, 32'h0);
        end
        @(posedge clk);
        #1;
        total++;
        assert (result === 32'h0) else begin
            bad++;
            $error("FAIL rst_cyc2: observed=%h expected=%h", result, 32'h0);
        end
        rst = 1'b0;
        check("rst_release_add", 5'd0, 32'd5, 32'd3, 32'd8);

        // reset wins over an operation in flight
        rst = 1'b1;
        check("rst_priority", 5'd0, 32'd100, 32'd200, 32'h0);
        rst = 1'b0;

        check("add_wrap",  5'd0, 32'hFFFFFFFF, 32'h1, 32'h0);
        check("sub_wrap",  5'd1, 32'h0, 32'h1, 32'hFFFFFFFF);
        check("xor",       5'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
        check("or",        5'd3, 32'hF0F0F0F0, 32'h0F00FF00, 32'hFFF0FFF0);
        check("and",       5'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);

        check("sll_mask",  5'd5, 32'h00000001, 32'h21, 32'h00000002);
        check("sll_31",    5'd5, 32'h00000003, 32'h1F, 32'h80000000);
        check("sra_mask",  5'd7, 32'h80000000, 32'h21, 32'hC0000000);
        check("srl_mask",  5'd6, 32'h80000000, 32'h21, 32'h40000000);
        check("sra_31",    5'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("sra_pos",   5'd7, 32'h40000000, 32'h4, 32'h04000000);
        check("slt_neg",   5'd8, 32'hFFFFFFFF, 32'h1, 32'h1);
        check("sltu_big",  5'd9, 32'hFFFFFFFF, 32'h1, 32'h0);
        check("slt_ge",    5'd8, 32'h5, 32'h3, 32'h0);
        check("sltu_lt",   5'd9, 32'h1, 32'hFFFFFFFF, 32'h1);
        check("slt_eq",    5'd8, 32'h80000000, 32'h80000000, 32'h0);

        check("mulh",      5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, mx(32'h0));
        check("mulhu",     5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, mx(32'hFFFFFFFE));
        check("mulhsu",    5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, mx(32'hFFFFFFFF));
        check("mul_ovf",   5'd10, 32'h00010000, 32'h00010000, mx(32'h0));
        check("mul_3x4",   5'd10, 32'd3, 32'd4, mx(32'd12));
        check("div_neg",   5'd14, 32'hFFFFFFF9, 32'd2, mx(32'hFFFFFFFD));
        check("rem_neg",   5'd16, 32'hFFFFFFF9, 32'd2, mx(32'hFFFFFFFF));
        check("div_zero",  5'd14, 32'd1234, 32'h0, mx(32'hFFFFFFFF));
        check("divu_zero", 5'd15, 32'd1234, 32'h0, mx(32'hFFFFFFFF));
        check("rem_zero",  5'd16, 32'hFFFFFFF0, 32'h0, mx(32'hFFFFFFF0));
        check("remu_zero", 5'd17, 32'd9, 32'h0, mx(32'd9));
        check("div_ovf",   5'd14, 32'h80000000, 32'hFFFFFFFF, mx(32'h80000000));
        check("rem_ovf",   5'd16, 32'h80000000, 32'hFFFFFFFF, mx(32'h0));
        check("divu",      5'd15, 32'd100, 32'd7, mx(32'd14));
        check("remu",      5'd17, 32'd100, 32'd7, mx(32'd2));
        check("div_pos_neg", 5'd14, 32'd7, 32'hFFFFFFFE, mx(32'hFFFFFFFD));
        check("rem_pos_neg", 5'd16, 32'd7, 32'hFFFFFFFE, mx(32'd1));

        check("add_after_m", 5'd0, 32'd40, 32'd2, 32'd42);
        check("op25",      5'd25, 32'h12345678, 32'h9ABCDEF0, 32'h0);
        check("op18",      5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
        check("op31",      5'd31, 32'h1, 32'h1, 32'h0);

        for (int op = 0; op < 5; op++) begin
            for (int i = 0; i < 1000; i++) begin
                logic [31:0] ra;
                logic [31:0] rb;
                ra = $urandom;
                rb = $urandom;
                check($sformatf("rand_op%0d_%0d", op, i), 5'(op), ra, rb,
                      base_model(5'(op), ra, rb));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
